// File: rtl/tjg_lab12_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tjg_lab12_bcd
// Description : Sequential 11-bit binary-to-BCD converter (double dabble) with
//               registered active-low seven-segment drivers and optional
//               leading-zero blanking, fed by the lab-12 multiplier product.
// Revision    : 1.0 - initial release
// ============================================================================
module tjg_lab12_bcd #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       cout_fp,
  input  logic [9:0] fp,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  // FSM encoding
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  // Counter value on the edge that performs the 11th (final) shift
  localparam logic [3:0] c_LAST_ITER = 4'd10;

  // All segments off (active-low)
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  // Registered state
  logic [1:0]  r_state;
  logic [10:0] r_bin;
  logic [15:0] r_scr;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_bcd3, r_bcd2, r_bcd1, r_bcd0;
  logic [6:0]  r_hex3, r_hex2, r_hex1, r_hex0;

  // Combinational
  logic [1:0]  w_next_state;
  logic [15:0] w_adj;
  logic [15:0] w_scr_next;
  logic [10:0] w_bin_next;
  logic        w_unused_carry;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_load_result;
  logic [6:0]  w_hex3_nxt, w_hex2_nxt, w_hex1_nxt, w_hex0_nxt;

  // Add-3 correction for one BCD digit so it doubles correctly on the shift
  function automatic logic [3:0] f_add3(input logic [3:0] d);
    f_add3 = (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Active-low seven-segment encoding, bit0=a ... bit6=g
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b1000000;
      4'd1:    f_seg = 7'b1111001;
      4'd2:    f_seg = 7'b0100100;
      4'd3:    f_seg = 7'b0110000;
      4'd4:    f_seg = 7'b0011001;
      4'd5:    f_seg = 7'b0010010;
      4'd6:    f_seg = 7'b0000010;
      4'd7:    f_seg = 7'b1111000;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0010000;
      default: f_seg = c_SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: correct each digit, then shift {scratch, binary}
  always_comb begin
    w_adj          = {f_add3(r_scr[15:12]), f_add3(r_scr[11:8]),
                      f_add3(r_scr[7:4]),   f_add3(r_scr[3:0])};
    w_scr_next     = {w_adj[14:0], r_bin[10]};
    w_bin_next     = {r_bin[9:0], 1'b0};
    // Bit shifted out of the top digit; always 0 for an 11-bit input
    w_unused_carry = w_adj[15];
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (load) begin
          w_next_state = c_SHIFT;
        end
      end
      c_SHIFT: begin
        if (r_cnt == c_LAST_ITER) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE: begin
        w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Output decode: flags follow the upcoming state so they are registered,
  // and the result is latched on the edge leaving the final shift
  always_comb begin
    w_busy_nxt    = (w_next_state == c_SHIFT);
    w_done_nxt    = (w_next_state == c_DONE);
    w_load_result = (r_state == c_SHIFT) && (w_next_state == c_DONE);
    w_hex0_nxt    = f_seg(w_scr_next[3:0]);
    w_hex1_nxt    = f_seg(w_scr_next[7:4]);
    w_hex2_nxt    = f_seg(w_scr_next[11:8]);
    w_hex3_nxt    = f_seg(w_scr_next[15:12]);
    if (BLANK_LZ) begin
      if (w_scr_next[15:12] == 4'd0) begin
        w_hex3_nxt = c_SEG_BLANK;
      end
      if (w_scr_next[15:8] == 8'd0) begin
        w_hex2_nxt = c_SEG_BLANK;
      end
      if (w_scr_next[15:4] == 12'd0) begin
        w_hex1_nxt = c_SEG_BLANK;
      end
    end
  end

  // Conversion datapath: capture in IDLE, one shift per SHIFT cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bin <= 11'd0;
      r_scr <= 16'd0;
      r_cnt <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (load) begin
            r_bin <= {cout_fp, fp};
            r_scr <= 16'd0;
            r_cnt <= 4'd0;
          end
        end
        c_SHIFT: begin
          r_bin <= w_bin_next;
          r_scr <= w_scr_next;
          r_cnt <= r_cnt + 4'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Output registers: flags every cycle, digits and segments on completion
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd3 <= 4'd0;
      r_bcd2 <= 4'd0;
      r_bcd1 <= 4'd0;
      r_bcd0 <= 4'd0;
      r_hex3 <= c_SEG_BLANK;
      r_hex2 <= c_SEG_BLANK;
      r_hex1 <= c_SEG_BLANK;
      r_hex0 <= c_SEG_BLANK;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_load_result) begin
        r_bcd3 <= w_scr_next[15:12];
        r_bcd2 <= w_scr_next[11:8];
        r_bcd1 <= w_scr_next[7:4];
        r_bcd0 <= w_scr_next[3:0];
        r_hex3 <= w_hex3_nxt;
        r_hex2 <= w_hex2_nxt;
        r_hex1 <= w_hex1_nxt;
        r_hex0 <= w_hex0_nxt;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd3 = r_bcd3;
  assign bcd2 = r_bcd2;
  assign bcd1 = r_bcd1;
  assign bcd0 = r_bcd0;
  assign hex3 = r_hex3;
  assign hex2 = r_hex2;
  assign hex1 = r_hex1;
  assign hex0 = r_hex0;

endmodule
`default_nettype wire

// File: doc/tjg_lab12_bcd.md
# tjg_lab12_bcd

Sequential binary-to-BCD converter and seven-segment driver that sits directly downstream of the lab-12 shift-add multiplier. It consumes the 10-bit product `fp` plus carry `cout_fp` as an 11-bit unsigned value (0–2047) on a `load` pulse. It converts the value with an 11-iteration double-dabble (shift-add-3) and latches four BCD digits and four active-low seven-segment patterns for the board displays. A one-cycle `done` pulse marks each new result.

## Interface
- `BLANK_LZ`, default 1: when 1, leading-zero digits in positions 3..1 are blanked (segments all off); digit 0 is never blanked.
- `clock`  in  1  rising-edge system clock (the only clock)
- `resetn`  in  1  asynchronous, active-low reset
- `load`  in  1  start request; sampled only in IDLE
- `cout_fp`  in  1  multiplier carry-out; bit 10 of the value
- `fp`  in  10  multiplier product; bits 9..0 of the value
- `busy`  out  1  high while a conversion is in progress (SHIFT state)
- `done`  out  1  one-cycle pulse; outputs updated on this cycle
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  out  4 each  thousands, hundreds, tens, units
- `hex3`, `hex2`, `hex1`, `hex0`  out  7 each  active-low segments, bit0=a … bit6=g

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with `load`=1, capture {`cout_fp`,`fp`} into the 11-bit binary shift register.
  - Clear the 16-bit scratch BCD, set the iteration counter to 0, go to SHIFT.
  - `load`=0: stay in IDLE.
- SHIFT, each edge:
  - Every scratch digit ≥5 gets +3 (4-bit, no carry between digits).
  - Then shift {scratch, binary} left by 1.
  - Counter increments; after the counter-10 edge (11th shift), go to DONE.
- Entering DONE:
  - `bcd3..0` are loaded from the final scratch value (computed combinationally so the 11th shift result is latched on the same edge).
  - `hex3..0` are encoded from those digits and registered on the same edge.
- DONE: `done`=1 for exactly one cycle; next edge returns to IDLE.
- `load` is ignored in SHIFT and DONE. There is no queueing: a held `load` restarts from IDLE, so one conversion completes per 13 cycles.
- Inputs are sampled only at capture; changes to `fp`/`cout_fp` during a conversion have no effect.
- Segment codes (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking with `BLANK_LZ`=1: `hex3` is blank if `bcd3`=0; `hex2` is blank if `bcd3`=`bcd2`=0; `hex1` is blank if `bcd3`=`bcd2`=`bcd1`=0.
- Digit range: `bcd3` ≤ 2; no BCD digit exceeds 9 for any 11-bit input.

## Timing
- Reset (`resetn`=0, asynchronous, any state):
  - state IDLE, `busy`=0, `done`=0.
  - `bcd3..0`=0, `hex3..0`=1111111.
  - Counter, shift register and scratch cleared.
  - Release takes effect at the next rising edge.
- Reset mid-conversion aborts it: no `done`, and outputs take reset values.
- Latency, with edge 0 being the IDLE edge where `load`=1:
  - `busy`=1 after edges 0..10; it falls after edge 11.
  - Results are visible and `done`=1 after edge 11.
  - `done`=0 after edge 12, back in IDLE.
  - 12 cycles from load to result.
- Outputs hold their last value until the next DONE entry or reset.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `load` with `fp`=945 (63×15), `cout_fp`=0 -> after 12 cycles `done` pulses once; bcd=0,9,4,5; `hex3`=1111111, `hex2`=0010000, `hex1`=0011001, `hex0`=0010010.
- `fp`=0, `cout_fp`=0 -> bcd=0,0,0,0; `hex3..1` blank, `hex0`=1000000; with `BLANK_LZ`=0, all four hex outputs =1000000.
- `fp`=10'h3FF, `cout_fp`=1 (2047) -> bcd=2,0,4,7; and `fp`=210 (21×10) -> bcd=0,2,1,0 with `hex3` blank and `hex0`=1000000 (an interior/trailing zero is not blanked).
- Start a conversion of 945, then pulse `load` with `fp`=5 at cycles 3 and 11 -> both ignored; result 945, single `done` pulse.
- Hold `load`=1 continuously and step `fp` 0,1,2 (with 0 held until its capture, then the next value) -> a new capture every 13 cycles; `done` pulses at cycles 11, 24, 37 with results 0, 1, 2.
- Convert 945 to completion, start a new conversion, and assert `resetn`=0 at cycle 6 -> immediately `busy`=0, bcd all 0, hex all 1111111; no `done` pulse; a fresh `load` after release converts correctly.
